vp_pixels_to_bitmap: RTL

//  Inverse of the video pipeline's bitmap-to-pixels expander: packs a row of 4-bit

---
 rtl/vp_pixels_to_bitmap.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vp_pixels_to_bitmap.sv
// Packs a word of palette pixels into a 1-bpp bitmap plus background/foreground colours.
// Four register stages deep (enable three clocks after the sampling edge), one word per clock, no backpressure.
module vp_pixels_to_bitmap #(
  parameter int PIXELS      = 16,
  parameter int COLOUR_BITS = 4,
  parameter int COUNT_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIXELS*COLOUR_BITS-1:0] pixels,
  input  logic                          enabled,
  input  logic                          clear_count,
  output logic [PIXELS-1:0]             bitmap,
  output logic [COLOUR_BITS-1:0]        foreground,
  output logic [COLOUR_BITS-1:0]        background,
  output logic                          enable,
  output logic                          lossy,
  output logic [COUNT_BITS-1:0]         lossy_count
);

  localparam int W  = PIXELS * COLOUR_BITS;
  localparam int CB = COLOUR_BITS;

  logic          s1_vld_q, s1_vld_d;
  logic [W-1:0]  s1_pix_q, s1_pix_d;
  logic          s2_vld_q, s2_vld_d;
  logic [W-1:0]  s2_pix_q, s2_pix_d;
  logic [CB-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic          s3_vld_q, s3_vld_d;
  logic [W-1:0]  s3_pix_q, s3_pix_d;
  logic [CB-1:0] s3_fg_q, s3_fg_d, s3_bg_q, s3_bg_d;
  logic          enable_q, enable_d;
  logic [PIXELS-1:0] bitmap_q, bitmap_d;
  logic [CB-1:0] fg_q, fg_d, bg_q, bg_d;
  logic          lossy_q, lossy_d;
  logic [COUNT_BITS-1:0] count_q, count_d;

  always_comb begin
    s1_vld_d = enabled;
    s1_pix_d = pixels;
  end

  // Colour B is the first pixel that differs from pixel 0; stays A for single-colour words.
  always_comb begin
    logic found;
    s2_vld_d = s1_vld_q;
    s2_pix_d = s1_pix_q;
    s2_a_d   = s1_pix_q[W-1 -: CB];
    s2_b_d   = s2_a_d;
    found    = 1'b0;
    for (int i = 1; i < PIXELS; i++) begin
      if (!found && (s1_pix_q[W-1-i*CB -: CB] != s2_a_d)) begin
        s2_b_d = s1_pix_q[W-1-i*CB -: CB];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    s3_vld_d = s2_vld_q;
    s3_pix_d = s2_pix_q;
    s3_bg_d  = (s2_a_q < s2_b_q) ? s2_a_q : s2_b_q;
    s3_fg_d  = (s2_a_q < s2_b_q) ? s2_b_q : s2_a_q;
  end

  // Any pixel that is not the background sets its bit, so third colours land on the foreground side.
  always_comb begin
    logic [CB-1:0] pix;
    enable_d = s3_vld_q;
    bitmap_d = bitmap_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    lossy_d  = lossy_q;
    pix      = '0;
    if (s3_vld_q) begin
      fg_d    = s3_fg_q;
      bg_d    = s3_bg_q;
      lossy_d = 1'b0;
      for (int i = 0; i < PIXELS; i++) begin
        pix                  = s3_pix_q[W-1-i*CB -: CB];
        bitmap_d[PIXELS-1-i] = (pix != s3_bg_q);
        if ((pix != s3_bg_q) && (pix != s3_fg_q)) lossy_d = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_count) begin
      count_d = '0;
    end else if (enable_q && lossy_q && (count_q != {COUNT_BITS{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s2_vld_q <= 1'b0;
      s2_pix_q <= '0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s3_vld_q <= 1'b0;
      s3_pix_q <= '0;
      s3_fg_q  <= '0;
      s3_bg_q  <= '0;
      enable_q <= 1'b0;
      bitmap_q <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      lossy_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_pix_q <= s1_pix_d;
      s2_vld_q <= s2_vld_d;
      s2_pix_q <= s2_pix_d;
      s2_a_q   <= s2_a_d;
      s2_b_q   <= s2_b_d;
      s3_vld_q <= s3_vld_d;
      s3_pix_q <= s3_pix_d;
      s3_fg_q  <= s3_fg_d;
      s3_bg_q  <= s3_bg_d;
      enable_q <= enable_d;
      bitmap_q <= bitmap_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      lossy_q  <= lossy_d;
      count_q  <= count_d;
    end
  end

  assign enable      = enable_q;
  assign bitmap      = bitmap_q;
  assign foreground  = fg_q;
  assign background  = bg_q;
  assign lossy       = lossy_q;
  assign lossy_count = count_q;

endmodule
